// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The master drives the byte stream and observes the writes; the slave is the loader.
interface inst_mem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory writer: framed byte stream in, 32-bit word writes out,
// CPU held in reset until the image and its XOR checksum are verified.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_LEN_LO | waiting for low byte of the word count
// S_LEN_HI | waiting for high byte; range-checks the count
// S_DATA   | assembling and writing image words
// S_CHECK  | waiting for the checksum byte
// S_DONE   | image verified, CPU released
// S_ERROR  | length overflow or checksum mismatch, CPU held
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  inst_mem_loader_if.slave   bus,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_error
);

  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  // 17 bits so that a full 2**16-word image is still representable
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t      state, state_next;
  logic [7:0]  len_lo;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [7:0]  xor_acc;
  logic [23:0] wbuf;

  logic        xfer;
  logic        last_byte;
  logic        last_word;
  logic        rearm;
  logic [16:0] len_full;

  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign last_word = (word_idx == word_cnt - 16'd1);
  assign rearm     = start && ((state == S_DONE) || (state == S_ERROR));
  assign len_full  = {1'b0, bus.byte_data, len_lo};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_LEN_LO;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    bus.byte_ready = 1'b0;
    case (state)
      S_LEN_LO: begin
        bus.byte_ready = 1'b1;
        if (xfer) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        bus.byte_ready = 1'b1;
        if (xfer) begin
          if (len_full > MAX_WORDS)  state_next = S_ERROR;
          else if (len_full == '0)   state_next = S_CHECK;
          else                       state_next = S_DATA;
        end
      end
      S_DATA: begin
        bus.byte_ready = 1'b1;
        if (xfer && last_byte && last_word) state_next = S_CHECK;
      end
      S_CHECK: begin
        bus.byte_ready = 1'b1;
        if (xfer) state_next = (bus.byte_data == xor_acc) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (start) state_next = S_LEN_LO;
      end
      default: state_next = S_LEN_LO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_hold      <= 1'b1;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      len_lo        <= '0;
      word_cnt      <= '0;
      word_idx      <= '0;
      byte_cnt      <= '0;
      xor_acc       <= '0;
      wbuf          <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      cpu_hold   <= (state_next != S_DONE);
      load_done  <= (state_next == S_DONE);
      load_error <= (state_next == S_ERROR);

      if (rearm) begin
        len_lo   <= '0;
        word_cnt <= '0;
        word_idx <= '0;
        byte_cnt <= '0;
        xor_acc  <= '0;
      end

      if (xfer) begin
        if (state != S_CHECK) xor_acc <= xor_acc ^ bus.byte_data;
        case (state)
          S_LEN_LO: len_lo   <= bus.byte_data;
          S_LEN_HI: word_cnt <= {bus.byte_data, len_lo};
          S_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            // the word is latched whole so mem_wdata never shows a partial word
            if (last_byte) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {14'd0, word_idx, 2'b00};
              bus.mem_wdata <= {wbuf, bus.byte_data};
              word_idx      <= word_idx + 16'd1;
            end else begin
              wbuf <= {wbuf[15:0], bus.byte_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
